// File: rtl/pipeline_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_sequencer_pkg
// Shared constants for the 5-stage pipeline sequencing logic:
//   - debug/run FSM state encodings (3-bit, visible on o_state)
//   - architectural register index 0 (never a real data dependency)
//   - default number of drain cycles after HALT leaves ID
// -----------------------------------------------------------------------------
package pipeline_sequencer_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_RUN    = 3'd1;
    localparam logic [2:0] ST_STEP   = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_HALTED = 3'd4;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int DRAIN_CYCLES_DEF = 3;

endpackage

// File: rtl/pipeline_sequencer_hazard_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
// Combinational load-use compare between the instruction in ID and a load
// sitting in ID/EX. Gating by freeze/FSM state is left to the caller so the
// same compare can be reused by the forwarding logic.
// Ports:
//   i_id_rs, i_id_rt    source registers of the ID instruction
//   i_id_uses_rt        ID instruction actually reads rt
//   i_idex_rt           destination of the instruction in ID/EX
//   i_idex_memRead      ID/EX instruction is a load
//   o_hazard            1 = ID must wait one cycle for the load data
// -----------------------------------------------------------------------------
module hazard_detect
    import pipeline_sequencer_pkg::*;
(
    input  logic [4:0] i_id_rs,
    input  logic [4:0] i_id_rt,
    input  logic       i_id_uses_rt,
    input  logic [4:0] i_idex_rt,
    input  logic       i_idex_memRead,
    output logic       o_hazard
);

    logic w_rs_match;
    logic w_rt_match;

    assign w_rs_match = (i_idex_rt == i_id_rs);
    // rt only counts when the ID instruction really reads it (I-type loads/ALU use rt as destination)
    assign w_rt_match = i_id_uses_rt && (i_idex_rt == i_id_rt);

    // Register 0 is hardwired, so a load targeting it never creates a dependency
    assign o_hazard = i_idex_memRead && (i_idex_rt != REG_ZERO) && (w_rs_match || w_rt_match);

endmodule

// File: rtl/pipeline_sequencer.sv
// -----------------------------------------------------------------------------
// pipeline_sequencer
// Central sequencing controller of the 5-stage pipeline. Owns the global
// freeze (hold) for all pipeline registers, the load-use bubble request, the
// PC / IF-ID write enables and the IF-ID flush. Runs the debug
// run/step/halt FSM and drains the pipeline after a HALT instruction.
// Ports:
//   clk, i_reset (async, active-low)
//   i_run_cmd / i_step_cmd / i_halt_cmd   debug command pulses
//   i_id_rs, i_id_rt, i_id_uses_rt        ID instruction sources
//   i_idex_rt, i_idex_memRead             load in ID/EX
//   i_ex_branch_taken                     taken branch/jump resolved in EX
//   i_id_is_halt                          HALT decoded in ID
//   o_freeze                              1 = hold every pipeline register
//   o_stall                               bubble into ID/EX
//   o_pc_write, o_ifid_write              update enables
//   o_flush                               clear IF/ID to NOP
//   o_state                               FSM state
//   o_halted                              program finished
//   o_step_done                           pulse after a single step
//   o_cycle_count                         saturating count of unfrozen cycles
// -----------------------------------------------------------------------------
module pipeline_sequencer
    import pipeline_sequencer_pkg::*;
#(
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             i_reset,
    input  logic             i_run_cmd,
    input  logic             i_step_cmd,
    input  logic             i_halt_cmd,
    input  logic [4:0]       i_id_rs,
    input  logic [4:0]       i_id_rt,
    input  logic             i_id_uses_rt,
    input  logic [4:0]       i_idex_rt,
    input  logic             i_idex_memRead,
    input  logic             i_ex_branch_taken,
    input  logic             i_id_is_halt,
    output logic             o_freeze,
    output logic             o_stall,
    output logic             o_pc_write,
    output logic             o_ifid_write,
    output logic             o_flush,
    output logic [2:0]       o_state,
    output logic             o_halted,
    output logic             o_step_done,
    output logic [CNT_W-1:0] o_cycle_count
);

    localparam int               DRN_W   = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [DRN_W-1:0] DRN_ONE = DRN_W'(1);
    localparam logic [DRN_W-1:0] DRN_LD  = DRN_W'(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [DRN_W-1:0] r_drain;
    logic [CNT_W-1:0] r_cycle_count;
    logic             r_step_done;

    logic w_freeze;
    logic w_active;
    logic w_hazard_raw;
    logic w_hazard;
    logic w_halt_det;

    hazard_detect u_hazard_detect (
        .i_id_rs        (i_id_rs),
        .i_id_rt        (i_id_rt),
        .i_id_uses_rt   (i_id_uses_rt),
        .i_idex_rt      (i_idex_rt),
        .i_idex_memRead (i_idex_memRead),
        .o_hazard       (w_hazard_raw)
    );

    // Freeze depends on registered state only; IDLE, HALTED and any illegal code hold the pipe
    assign w_freeze = !((r_state == ST_RUN) || (r_state == ST_STEP) || (r_state == ST_DRAIN));
    // RUN/STEP are the only states where the ID instruction may advance normally
    assign w_active = (r_state == ST_RUN) || (r_state == ST_STEP);
    assign w_hazard = w_active && w_hazard_raw;
    // A HALT behind a taken branch is on the wrong path and must not be honoured
    assign w_halt_det = w_active && i_id_is_halt && !i_ex_branch_taken;

    // Next-state logic of the debug run/step/halt FSM
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_halt_cmd) begin
                    w_state_nxt = ST_IDLE;
                end else if (i_step_cmd) begin
                    w_state_nxt = ST_STEP;
                end else if (i_run_cmd) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (i_halt_cmd) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_halt_det) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_STEP: begin
                if (w_halt_det) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                // <= also catches a zero-length drain configuration
                if (r_drain <= DRN_ONE) begin
                    w_state_nxt = ST_HALTED;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_HALTED: begin
                w_state_nxt = ST_HALTED;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Same-cycle pipeline controls: must block the very edge that would move the pipe
    always_comb begin
        o_stall      = 1'b0;
        o_flush      = 1'b0;
        o_pc_write   = 1'b0;
        o_ifid_write = 1'b0;
        if (w_freeze) begin
            o_stall      = 1'b0;
            o_flush      = 1'b0;
            o_pc_write   = 1'b0;
            o_ifid_write = 1'b0;
        end else if (r_state == ST_DRAIN) begin
            // HALT parked in IF/ID; feed bubbles until older instructions retire
            o_stall      = 1'b1;
            o_flush      = 1'b0;
            o_pc_write   = 1'b0;
            o_ifid_write = 1'b0;
        end else if (i_ex_branch_taken) begin
            // ID holds a wrong-path instruction, so its load-use stall is moot
            o_stall      = 1'b0;
            o_flush      = 1'b1;
            o_pc_write   = 1'b1;
            o_ifid_write = 1'b1;
        end else if (w_halt_det) begin
            o_stall      = w_hazard;
            o_flush      = 1'b0;
            o_pc_write   = 1'b0;
            o_ifid_write = 1'b0;
        end else if (w_hazard) begin
            o_stall      = 1'b1;
            o_flush      = 1'b0;
            o_pc_write   = 1'b0;
            o_ifid_write = 1'b0;
        end else begin
            o_stall      = 1'b0;
            o_flush      = 1'b0;
            o_pc_write   = 1'b1;
            o_ifid_write = 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Drain counter: loaded on HALT detection, counts down while draining
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            r_drain <= '0;
        end else if (w_halt_det) begin
            r_drain <= DRN_LD;
        end else if ((r_state == ST_DRAIN) && (r_drain != '0)) begin
            r_drain <= r_drain - DRN_ONE;
        end else begin
            r_drain <= r_drain;
        end
    end

    // Saturating count of unfrozen cycles
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            r_cycle_count <= '0;
        end else if (!w_freeze && (r_cycle_count != CNT_MAX)) begin
            r_cycle_count <= r_cycle_count + CNT_ONE;
        end else begin
            r_cycle_count <= r_cycle_count;
        end
    end

    // Step-done pulse in the cycle after the single unfrozen STEP cycle
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            r_step_done <= 1'b0;
        end else begin
            r_step_done <= (r_state == ST_STEP);
        end
    end

    assign o_freeze      = w_freeze;
    assign o_halted      = (r_state == ST_HALTED);
    assign o_state       = r_state;
    assign o_step_done   = r_step_done;
    assign o_cycle_count = r_cycle_count;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pipeline_sequencer
// Self-checking bench: directed scenarios followed by randomized stimulus,
// every cycle compared against a behavioural model of the sequencer kept
// here (mode as a name, drain as a remaining-cycles count).
// -----------------------------------------------------------------------------
module tb_pipeline_sequencer;

    logic        clk;
    logic        i_reset;
    logic        i_run_cmd;
    logic        i_step_cmd;
    logic        i_halt_cmd;
    logic [4:0]  i_id_rs;
    logic [4:0]  i_id_rt;
    logic        i_id_uses_rt;
    logic [4:0]  i_idex_rt;
    logic        i_idex_memRead;
    logic        i_ex_branch_taken;
    logic        i_id_is_halt;
    logic        o_freeze;
    logic        o_stall;
    logic        o_pc_write;
    logic        o_ifid_write;
    logic        o_flush;
    logic [2:0]  o_state;
    logic        o_halted;
    logic        o_step_done;
    logic [31:0] o_cycle_count;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    string       m_mode;      // "IDLE","RUN","STEP","DRAIN","HALTED"
    int          m_left;      // drain cycles still to go
    logic [31:0] m_cnt;
    logic        m_done;

    pipeline_sequencer dut (
        .clk               (clk),
        .i_reset           (i_reset),
        .i_run_cmd         (i_run_cmd),
        .i_step_cmd        (i_step_cmd),
        .i_halt_cmd        (i_halt_cmd),
        .i_id_rs           (i_id_rs),
        .i_id_rt           (i_id_rt),
        .i_id_uses_rt      (i_id_uses_rt),
        .i_idex_rt         (i_idex_rt),
        .i_idex_memRead    (i_idex_memRead),
        .i_ex_branch_taken (i_ex_branch_taken),
        .i_id_is_halt      (i_id_is_halt),
        .o_freeze          (o_freeze),
        .o_stall           (o_stall),
        .o_pc_write        (o_pc_write),
        .o_ifid_write      (o_ifid_write),
        .o_flush           (o_flush),
        .o_state           (o_state),
        .o_halted          (o_halted),
        .o_step_done       (o_step_done),
        .o_cycle_count     (o_cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int mode_code(input string m);
        case (m)
            "IDLE":   return 0;
            "RUN":    return 1;
            "STEP":   return 2;
            "DRAIN":  return 3;
            "HALTED": return 4;
            default:  return 7;
        endcase
    endfunction

    task automatic clr_inputs();
        i_run_cmd = 1'b0; i_step_cmd = 1'b0; i_halt_cmd = 1'b0;
        i_id_rs = 5'd0; i_id_rt = 5'd0; i_id_uses_rt = 1'b0;
        i_idex_rt = 5'd0; i_idex_memRead = 1'b0;
        i_ex_branch_taken = 1'b0; i_id_is_halt = 1'b0;
    endtask

    task automatic model_reset();
        m_mode = "IDLE"; m_left = 0; m_cnt = 32'd0; m_done = 1'b0;
    endtask

    // One clock: entered just after a negedge with inputs applied; checks, then advances the model
    task automatic tick();
        bit frozen, executing, lu, halt_seen, e_stall, e_flush, e_pc, e_ifid;
        #1;
        frozen    = (m_mode == "IDLE") || (m_mode == "HALTED");
        executing = (m_mode == "RUN") || (m_mode == "STEP");
        lu = i_idex_memRead && (i_idex_rt != 5'd0) &&
             ((i_idex_rt == i_id_rs) || (i_id_uses_rt && (i_idex_rt == i_id_rt)));
        halt_seen = executing && i_id_is_halt && !i_ex_branch_taken;
        if (frozen) begin
            e_stall = 1'b0; e_flush = 1'b0; e_pc = 1'b0; e_ifid = 1'b0;
        end else if (m_mode == "DRAIN") begin
            e_stall = 1'b1; e_flush = 1'b0; e_pc = 1'b0; e_ifid = 1'b0;
        end else begin
            e_flush = i_ex_branch_taken;
            e_stall = lu && !i_ex_branch_taken;
            e_pc    = i_ex_branch_taken || !(lu || halt_seen);
            e_ifid  = !(lu || halt_seen);
        end
        check_val("state",     o_state,       mode_code(m_mode));
        check_val("freeze",    o_freeze,      frozen);
        check_val("halted",    o_halted,      m_mode == "HALTED");
        check_val("step_done", o_step_done,   m_done);
        check_val("cycles",    o_cycle_count, m_cnt);
        check_val("stall",     o_stall,       e_stall);
        check_val("flush",     o_flush,       e_flush);
        check_val("pc_write",  o_pc_write,    e_pc);
        if (!e_flush) check_val("ifid_write", o_ifid_write, e_ifid);
        @(posedge clk);
        if (!frozen && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        m_done = (m_mode == "STEP");
        if (halt_seen) m_left = 3;
        case (m_mode)
            "IDLE": begin
                if (i_halt_cmd)      m_mode = "IDLE";
                else if (i_step_cmd) m_mode = "STEP";
                else if (i_run_cmd)  m_mode = "RUN";
            end
            "RUN": begin
                if (i_halt_cmd)     m_mode = "IDLE";
                else if (halt_seen) m_mode = "DRAIN";
            end
            "STEP": m_mode = halt_seen ? "DRAIN" : "IDLE";
            "DRAIN": begin
                m_left = m_left - 1;
                if (m_left <= 0) m_mode = "HALTED";
            end
            default: ;
        endcase
        @(negedge clk);
    endtask

    // Asynchronous reset in the middle of a cycle, checked before any clock edge
    task automatic do_reset();
        #2 i_reset = 1'b0;
        #1;
        check_val("rst_state",  o_state,       3'd0);
        check_val("rst_cycles", o_cycle_count, 32'd0);
        check_val("rst_freeze", o_freeze,      1'b1);
        check_val("rst_pcw",    o_pc_write,    1'b0);
        check_val("rst_halted", o_halted,      1'b0);
        check_val("rst_sdone",  o_step_done,   1'b0);
        model_reset();
        @(negedge clk);
        i_reset = 1'b1;
    endtask

    initial begin
        clr_inputs();
        model_reset();
        i_reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_val("rst_stall", o_stall, 1'b0);
        check_val("rst_flush", o_flush, 1'b0);
        check_val("rst_ifidw", o_ifid_write, 1'b0);
        i_reset = 1'b1;
        tick();

        // Run, count 5 unfrozen cycles, then pause
        i_run_cmd = 1'b1; tick(); i_run_cmd = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check_val("run_cnt", o_cycle_count, 32'd5);
        i_halt_cmd = 1'b1; tick(); i_halt_cmd = 1'b0;
        tick();

        // Three single steps spaced 4 cycles apart
        do_reset();
        for (int i = 0; i < 3; i++) begin
            i_step_cmd = 1'b1; tick(); i_step_cmd = 1'b0;
            for (int k = 0; k < 3; k++) tick();
        end
        check_val("step_cnt", o_cycle_count, 32'd3);

        // Load-use stall, r0 exemption, flush override
        do_reset();
        i_run_cmd = 1'b1; tick(); i_run_cmd = 1'b0;
        i_idex_memRead = 1'b1; i_idex_rt = 5'd5; i_id_rs = 5'd5;
        tick();
        i_idex_rt = 5'd0; i_id_rs = 5'd0; tick();
        i_idex_rt = 5'd5; i_id_rs = 5'd5; i_ex_branch_taken = 1'b1; tick();
        clr_inputs();

        // HALT drains then freezes; later run ignored
        i_id_is_halt = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        i_run_cmd = 1'b1; tick(); i_run_cmd = 1'b0;
        tick();
        check_val("halt_sticky", o_halted, 1'b1);
        clr_inputs();

        // Halt and step together in RUN
        do_reset();
        i_run_cmd = 1'b1; tick(); i_run_cmd = 1'b0;
        tick();
        i_halt_cmd = 1'b1; i_step_cmd = 1'b1; tick(); clr_inputs();
        tick(); tick();

        // Reset during DRAIN
        i_run_cmd = 1'b1; tick(); i_run_cmd = 1'b0;
        i_id_is_halt = 1'b1; tick(); tick();
        do_reset();
        clr_inputs();
        tick();

        // Randomized stimulus
        for (int n = 0; n < 1500; n++) begin
            int r;
            clr_inputs();
            r = $urandom_range(0, 19);
            i_run_cmd  = (r == 0) || (r == 3);
            i_step_cmd = (r == 1) || (r == 3);
            i_halt_cmd = (r == 2);
            i_id_rs        = 5'($urandom_range(0, 3));
            i_id_rt        = 5'($urandom_range(0, 3));
            i_idex_rt      = 5'($urandom_range(0, 3));
            i_id_uses_rt   = 1'($urandom_range(0, 1));
            i_idex_memRead = 1'($urandom_range(0, 1));
            i_ex_branch_taken = ($urandom_range(0, 7) == 0);
            i_id_is_halt      = ($urandom_range(0, 39) == 0);
            if (m_mode == "HALTED" && $urandom_range(0, 3) == 0) begin
                do_reset();
            end else if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                tick();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
